id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_if.sv | 26 ++
 rtl/id_ex_stage.sv | 61 ++++++
 2 files changed

// File: rtl/id_ex_if.sv
// id_ex_if: ID/EX pipeline boundary bundle (ID payload in, EX register and hazard status out)
interface id_ex_if #(parameter int CNT_W = 16);
  logic ID_valid, ID_RFWr, ID_use1, ID_use2;
  logic [4:0] ID_rR1, ID_rR2, ID_wR;
  logic [1:0] ID_WDSel;
  logic [31:0] ID_pc4, ID_ext, ID_rD1, ID_rD2;
  logic hold, flush;
  logic EX_running, EX_RFWr;
  logic [31:0] EX_wR;
  logic [1:0] EX_WDSel;
  logic [31:0] EX_pc4, EX_ext, EX_rD1, EX_rD2;
  logic stall_ID;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;
  modport master (
    output ID_valid, ID_RFWr, ID_use1, ID_use2, ID_rR1, ID_rR2, ID_wR, ID_WDSel,
           ID_pc4, ID_ext, ID_rD1, ID_rD2, hold, flush,
    input  EX_running, EX_RFWr, EX_wR, EX_WDSel, EX_pc4, EX_ext, EX_rD1, EX_rD2,
           stall_ID, bubble_cnt, flush_cnt
  );
  modport slave (
    input  ID_valid, ID_RFWr, ID_use1, ID_use2, ID_rR1, ID_rR2, ID_wR, ID_WDSel,
           ID_pc4, ID_ext, ID_rD1, ID_rD2, hold, flush,
    output EX_running, EX_RFWr, EX_wR, EX_WDSel, EX_pc4, EX_ext, EX_rD1, EX_rD2,
           stall_ID, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush, freeze and event counters
module id_ex_stage #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst,
  id_ex_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, RUN, BUBBLE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_nx;
  logic running, rfwr, lu, load, hit1, hit2;
  logic [4:0] wr;
  logic [1:0] wdsel;
  logic [31:0] pc4, ext, rd1, rd2;
  logic [CNT_W-1:0] bcnt, fcnt;
  assign hit1 = bus.ID_use1 && bus.ID_rR1 == wr;
  assign hit2 = bus.ID_use2 && bus.ID_rR2 == wr;
  assign lu = bus.ID_valid && running && rfwr && wdsel == 2'd1 && wr != 5'd0 && (hit1 || hit2);
  assign load = !bus.hold && !bus.flush && !lu;
  always_ff @(posedge clk)
    state <= rst ? EMPTY : state_nx;
  always_comb
    state_nx = bus.hold ? state : bus.flush ? EMPTY : lu ? BUBBLE : bus.ID_valid ? RUN : EMPTY;
  always_comb
    running = state == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      rfwr <= 1'b0;
      wr <= '0;
      wdsel <= '0;
      pc4 <= '0;
      ext <= '0;
      rd1 <= '0;
      rd2 <= '0;
      bcnt <= '0;
      fcnt <= '0;
    end else if (!bus.hold) begin
      rfwr <= load && bus.ID_valid && bus.ID_RFWr;
      if (load) begin
        wr <= bus.ID_wR;
        wdsel <= bus.ID_WDSel;
        pc4 <= bus.ID_pc4;
        ext <= bus.ID_ext;
        rd1 <= bus.ID_rD1;
        rd2 <= bus.ID_rD2;
      end
      if (bus.flush && fcnt != CNT_MAX) fcnt <= fcnt + 1'b1;
      if (!bus.flush && lu && bcnt != CNT_MAX) bcnt <= bcnt + 1'b1;
    end
  end
  assign bus.stall_ID = (lu && !bus.flush) || bus.hold;
  assign bus.EX_running = running;
  assign bus.EX_RFWr = rfwr;
  assign bus.EX_wR = {27'd0, wr};
  assign bus.EX_WDSel = wdsel;
  assign bus.EX_pc4 = pc4;
  assign bus.EX_ext = ext;
  assign bus.EX_rD1 = rd1;
  assign bus.EX_rD2 = rd2;
  assign bus.bubble_cnt = bcnt;
  assign bus.flush_cnt = fcnt;
endmodule
